// File: rtl/ysyx_22050612_lsu_pkg.sv
// Shared LSU types: access size encodings, FSM states, byte-count helper.
// Purely declarative; no latency or backpressure of its own.
package ysyx_22050612_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_align.sv
// Lane alignment: store mask/data shift and load extract with sign/zero extension.
// Combinational, zero latency; no handshake, so no backpressure.
module ysyx_22050612_lsu_align
    import ysyx_22050612_lsu_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [1:0]    st_size,
    input  logic [2:0]    st_off,
    input  logic [DW-1:0] st_wdata,
    output logic [7:0]    st_wmask,
    output logic [DW-1:0] st_wdata_lane,
    input  logic [1:0]    ld_size,
    input  logic [2:0]    ld_off,
    input  logic          ld_unsigned,
    input  logic [DW-1:0] ld_rdata,
    output logic [DW-1:0] ld_result
);
    logic [7:0]    base_mask;
    logic [DW-1:0] ld_shifted;

    always_comb begin
        case (st_size)
            SZ_B:    base_mask = 8'h01;
            SZ_H:    base_mask = 8'h03;
            SZ_W:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        st_wmask      = base_mask << st_off;
        st_wdata_lane = st_wdata << {st_off, 3'b000};
    end

    // A doubleword load always returns the full lane, so in_unsigned has no effect on it.
    always_comb begin
        ld_shifted = ld_rdata >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B: ld_result = ld_unsigned ? {{(DW-8){1'b0}}, ld_shifted[7:0]}
                                          : {{(DW-8){ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_H: ld_result = ld_unsigned ? {{(DW-16){1'b0}}, ld_shifted[15:0]}
                                          : {{(DW-16){ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W: ld_result = ld_unsigned ? {{(DW-32){1'b0}}, ld_shifted[31:0]}
                                          : {{(DW-32){ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_result = ld_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22050612_lsu.sv
// Single-outstanding load/store unit; accept->out_valid is 3 cycles best case, 1 for misaligned.
// in_ready is low from accept until the result handshake; request and result are held until their readies.
module ysyx_22050612_lsu
    import ysyx_22050612_lsu_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_wen,
    input  logic [1:0]    in_size,
    input  logic          in_unsigned,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    input  logic [4:0]    in_rd,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    output logic          mem_req_wen,
    output logic [7:0]    mem_req_wmask,
    output logic [DW-1:0] mem_req_wdata,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_resp_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_rdata,
    output logic [4:0]    out_rd,
    output logic          out_reg_wen,
    output logic          out_misalign
);
    lsu_state_e    state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          req_valid_q, req_valid_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic          wen_q, wen_d;
    logic [7:0]    wmask_q, wmask_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic [2:0]    off_q, off_d;
    logic          unsigned_q, unsigned_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [4:0]    rd_q, rd_d;
    logic          reg_wen_q, reg_wen_d;
    logic          misalign_q, misalign_d;

    logic [7:0]    st_wmask;
    logic [DW-1:0] st_wdata_lane;
    logic [DW-1:0] ld_result;
    logic          in_misalign;

    ysyx_22050612_lsu_align #(.DW(DW)) u_align (
        .st_size       (in_size),
        .st_off        (in_addr[2:0]),
        .st_wdata      (in_wdata),
        .st_wmask      (st_wmask),
        .st_wdata_lane (st_wdata_lane),
        .ld_size       (size_q),
        .ld_off        (off_q),
        .ld_unsigned   (unsigned_q),
        .ld_rdata      (mem_resp_rdata),
        .ld_result     (ld_result)
    );

    assign in_misalign = ({1'b0, in_addr[2:0]} + size_bytes(in_size)) > 4'd8;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        wen_d       = wen_q;
        wmask_d     = wmask_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        off_d       = off_q;
        unsigned_d  = unsigned_q;
        out_valid_d = out_valid_q;
        rdata_d     = rdata_q;
        rd_d        = rd_q;
        reg_wen_d   = reg_wen_q;
        misalign_d  = misalign_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    req_addr_d = {in_addr[AW-1:3], 3'b000};
                    wen_d      = in_wen;
                    wmask_d    = st_wmask;
                    wdata_d    = st_wdata_lane;
                    size_d     = in_size;
                    off_d      = in_addr[2:0];
                    unsigned_d = in_unsigned;
                    rd_d       = in_rd;
                    if (in_misalign) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        misalign_d  = 1'b1;
                        reg_wen_d   = 1'b0;
                        rdata_d     = '0;
                    end else begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                        misalign_d  = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                // Stores also wait here: the response doubles as the write acknowledgement.
                if (mem_resp_valid) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    rdata_d     = wen_q ? '0 : ld_result;
                    reg_wen_d   = !wen_q && (rd_q != 5'd0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            wen_q       <= 1'b0;
            wmask_q     <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            off_q       <= '0;
            unsigned_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rdata_q     <= '0;
            rd_q        <= '0;
            reg_wen_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            wen_q       <= wen_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            off_q       <= off_d;
            unsigned_q  <= unsigned_d;
            out_valid_q <= out_valid_d;
            rdata_q     <= rdata_d;
            rd_q        <= rd_d;
            reg_wen_q   <= reg_wen_d;
            misalign_q  <= misalign_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wmask = wmask_q;
    assign mem_req_wdata = wdata_q;
    assign out_valid     = out_valid_q;
    assign out_rdata     = rdata_q;
    assign out_rd        = rd_q;
    assign out_reg_wen   = reg_wen_q;
    assign out_misalign  = misalign_q;

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Scoreboard bench for the LSU: directed loads/stores, stall and reset scenarios.
module tb_ysyx_22050612_lsu;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } req_t;

    typedef struct {
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        reg_wen;
        logic        misalign;
    } out_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_wen, in_unsigned;
    logic [1:0]  in_size;
    logic [63:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        out_valid, out_ready, out_reg_wen, out_misalign;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;

    int checks = 0;
    int errors = 0;
    int bus_txns = 0;
    int req_delay = 0;
    int resp_delay = 0;
    int out_delay = 0;
    req_t req_q[$];
    out_t out_q[$];

    ysyx_22050612_lsu #(.AW(64), .DW(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wen         (in_wen),
        .in_size        (in_size),
        .in_unsigned    (in_unsigned),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_rd          (in_rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wmask  (mem_req_wmask),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_rd         (out_rd),
        .out_reg_wen    (out_reg_wen),
        .out_misalign   (out_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus slave: checks each request against the scoreboard, stalls, then answers.
    initial begin : bus_model
        req_t cur;
        int   cnt;
        int   st;
        bit   seen;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        cur = '{default: '0};
        cnt = 0;
        st = 0;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (st == 1) begin
                mem_req_ready = 1'b0;
                bus_txns++;
                cnt = resp_delay;
                st = 2;
                seen = 1'b0;
            end
            if (st == 2) begin
                if (cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = cur.rdata;
                    st = 0;
                end else begin
                    cnt--;
                end
            end else if (st == 0 && mem_req_valid) begin
                chk("bus_in_ready", in_ready, 0);
                if (!seen) begin
                    chk("req_expected", req_q.size() > 0, 1);
                    if (req_q.size() > 0) cur = req_q.pop_front();
                    else cur = '{default: '0};
                    seen = 1'b1;
                    cnt = 0;
                end
                chk("req_fields", {mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata},
                                  {cur.addr, cur.wen, cur.wmask, cur.wdata});
                if (cnt >= req_delay) begin
                    mem_req_ready = 1'b1;
                    st = 1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Result monitor: pops the expected result on first sight and rechecks every held cycle.
    initial begin : out_monitor
        out_t exp;
        int   cnt;
        bit   seen;
        bit   hs;
        out_ready = 1'b0;
        exp = '{default: '0};
        cnt = 0;
        seen = 1'b0;
        hs = 1'b0;
        forever begin
            @(negedge clk);
            if (hs) begin
                out_ready = 1'b0;
                seen = 1'b0;
                hs = 1'b0;
            end
            if (out_valid) begin
                chk("out_in_ready", in_ready, 0);
                if (!seen) begin
                    chk("out_expected", out_q.size() > 0, 1);
                    if (out_q.size() > 0) exp = out_q.pop_front();
                    else exp = '{default: '0};
                    seen = 1'b1;
                    cnt = 0;
                end
                chk("out_fields", {out_rdata, out_rd, out_reg_wen, out_misalign},
                                  {exp.rdata, exp.rd, exp.reg_wen, exp.misalign});
                if (cnt >= out_delay) begin
                    out_ready = 1'b1;
                    hs = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_wen = wen;
        in_size = size;
        in_unsigned = uns;
        in_addr = addr;
        in_wdata = wdata;
        in_rd = rd;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accept_timeout", ok, 1);
    endtask

    task automatic tx(input logic wen, input logic [1:0] size, input logic uns,
                      input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                      input logic [63:0] req_addr, input logic [7:0] exp_mask,
                      input logic [63:0] exp_wdata, input logic [63:0] rdata,
                      input logic [63:0] exp_rdata, input logic exp_reg_wen,
                      input logic exp_mis, input int exp_lat);
        req_t r;
        out_t o;
        int   base;
        int   lat;
        bit   ok;
        base = bus_txns;
        if (!exp_mis) begin
            r.addr = req_addr;
            r.wen = wen;
            r.wmask = exp_mask;
            r.wdata = exp_wdata;
            r.rdata = rdata;
            req_q.push_back(r);
        end
        o.rdata = exp_rdata;
        o.rd = rd;
        o.reg_wen = exp_reg_wen;
        o.misalign = exp_mis;
        out_q.push_back(o);
        issue(wen, size, uns, addr, wdata, rd);
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) ok = 1'b1;
        end
        chk("out_timeout", ok, 1);
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        chk("done_timeout", ok, 1);
        chk("bus_txn_count", bus_txns - base, exp_mis ? 0 : 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        req_t r;
        int   base;
        bit   ok;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_wen = 1'b0;
        in_size = 2'd0;
        in_unsigned = 1'b0;
        in_addr = '0;
        in_wdata = '0;
        in_rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flags", {out_reg_wen, out_misalign}, 0);
        chk("rst_out_data", {out_rdata, out_rd}, 0);
        chk("rst_req_fields", {mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // wen size uns addr wdata rd | req_addr mask wdata rdata | result reg_wen mis lat
        tx(0, 2'd2, 0, 64'h80000004, 64'h0, 5'd5,
           64'h80000000, 8'hF0, 64'h0, 64'h80000000_12345678,
           64'hFFFFFFFF_80000000, 1, 0, 3);
        tx(1, 2'd0, 0, 64'h80000003, 64'hAB, 5'd0,
           64'h80000000, 8'h08, 64'h00000000_AB000000, 64'h0,
           64'h0, 0, 0, 3);
        tx(0, 2'd1, 0, 64'h80000007, 64'h0, 5'd4,
           64'h0, 8'h00, 64'h0, 64'h0,
           64'h0, 0, 1, 1);
        tx(0, 2'd0, 1, 64'h80000006, 64'h0, 5'd10,
           64'h80000000, 8'h40, 64'h0, 64'hFF9C0000_00000000,
           64'h00000000_0000009C, 1, 0, 3);
        tx(0, 2'd0, 0, 64'h80000006, 64'h0, 5'd11,
           64'h80000000, 8'h40, 64'h0, 64'hFF9C0000_00000000,
           64'hFFFFFFFF_FFFFFF9C, 1, 0, 3);
        tx(0, 2'd3, 1, 64'h80000008, 64'h0, 5'd12,
           64'h80000008, 8'hFF, 64'h0, 64'h81234567_89ABCDEF,
           64'h81234567_89ABCDEF, 1, 0, 3);
        tx(1, 2'd1, 0, 64'h80000006, 64'hBEEF, 5'd13,
           64'h80000000, 8'hC0, 64'hBEEF0000_00000000, 64'h0,
           64'h0, 0, 0, 3);
        tx(0, 2'd2, 0, 64'h80000005, 64'h0, 5'd7,
           64'h0, 8'h00, 64'h0, 64'h0,
           64'h0, 0, 1, 1);
        tx(0, 2'd1, 0, 64'h80000002, 64'h0, 5'd14,
           64'h80000000, 8'h0C, 64'h0, 64'h00000000_80010000,
           64'hFFFFFFFF_FFFF8001, 1, 0, 3);
        tx(0, 2'd2, 1, 64'h80000000, 64'h0, 5'd0,
           64'h80000000, 8'h0F, 64'h0, 64'hDEADBEEF_F0000001,
           64'h00000000_F0000001, 0, 0, 3);

        // Bus stall then result stall: latency becomes 3 + 4 request-wait cycles.
        req_delay = 4;
        out_delay = 3;
        tx(1, 2'd3, 0, 64'h80000010, 64'h11223344_55667788, 5'd3,
           64'h80000010, 8'hFF, 64'h11223344_55667788, 64'h0,
           64'h0, 0, 0, 7);
        tx(0, 2'd2, 0, 64'h80000014, 64'h0, 5'd6,
           64'h80000010, 8'hF0, 64'h0, 64'h7FFFFFFF_00000000,
           64'h00000000_7FFFFFFF, 1, 0, 7);
        req_delay = 0;
        out_delay = 0;

        // Reset while waiting for the response; the late response must be ignored.
        resp_delay = 3;
        base = bus_txns;
        r.addr = 64'h80000020;
        r.wen = 1'b0;
        r.wmask = 8'hFF;
        r.wdata = 64'h0;
        r.rdata = 64'h55;
        req_q.push_back(r);
        issue(0, 2'd3, 0, 64'h80000020, 64'h0, 5'd9);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus_txns == base + 1) ok = 1'b1;
        end
        chk("rst_test_handshake", ok, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_req_valid", mem_req_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("late_resp_ignored", {out_valid, in_ready, mem_req_valid}, 3'b010);
        end
        resp_delay = 0;

        // The unit must still work normally after the abandoned transaction.
        tx(0, 2'd0, 0, 64'h80000001, 64'h0, 5'd8,
           64'h80000000, 8'h02, 64'h0, 64'h00000000_00007F00,
           64'h00000000_0000007F, 1, 0, 3);

        repeat (3) @(negedge clk);
        chk("req_q_drained", req_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_lsu.md
YSYX_22050612_LSU -- requirements
Module: ysyx_22050612_LSU

Interface
REQ-001 Parameter: AW, 64, address width.
REQ-002 Parameter: DW, 64, data/bus width; the only supported value is 64.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid / in_ready  in / out  1 / 1  request handshake from EXU.
REQ-006 Port: in_wen  in  1  1 = store, 0 = load.
REQ-007 Port: in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-008 Port: in_unsigned  in  1  zero-extend the load result (LBU/LHU/LWU).
REQ-009 Port: in_addr  in  AW  effective byte address from the EXU ALU.
REQ-010 Port: in_wdata  in  DW  store data, LSB-justified (rs2).
REQ-011 Port: in_rd  in  5  destination register tag.
REQ-012 Port: mem_req_valid / mem_req_ready  out / in  1 / 1  bus request handshake.
REQ-013 Port: mem_req_addr  out  AW  in_addr with bits [2:0] forced to 0.
REQ-014 Port: mem_req_wen / mem_req_wmask / mem_req_wdata  out  1 / 8 / DW  lane-aligned write.
REQ-015 Port: mem_resp_valid / mem_resp_rdata  in  1 / DW  bus response; always accepted.
REQ-016 Port: out_valid / out_ready  out / in  1 / 1  result handshake to WBU.
REQ-017 Port: out_rdata / out_rd / out_reg_wen / out_misalign  out  DW / 5 / 1 / 1  result.

Function
REQ-018 FSM states: IDLE, REQ, RESP, DONE; one transaction in flight at a time.
REQ-019 IDLE: in_ready=1; on in_valid, register all in_* fields and go to REQ, or to DONE if misaligned.
REQ-020 Misaligned means the access crosses an 8-byte boundary: (addr[2:0] + bytes) > 8.
REQ-021 A misaligned access issues no bus request; DONE then drives out_misalign=1 and out_reg_wen=0.
REQ-022 REQ: mem_req_valid=1 with stable address, wen, mask and data until mem_req_ready; go to RESP on the same edge.
REQ-023 Byte mask = ((1<<bytes)-1) << addr[2:0]; wdata = in_wdata << (8*addr[2:0]).
REQ-024 RESP: wait for mem_resp_valid for both loads (data) and stores (acknowledgement); then go to DONE.
REQ-025 Load extract: shift rdata right by 8*addr[2:0], take the low `bytes`, then sign- or zero-extend to 64 bits. LD ignores in_unsigned.
REQ-026 The load result is registered at the response edge; out_reg_wen = !wen && rd != 0.
REQ-027 DONE: out_valid=1 with stable outputs until out_ready; go to IDLE on that edge.
REQ-028 in_ready=0 in REQ, RESP and DONE; a request is never accepted in the same cycle as the DONE handshake.
REQ-029 mem_resp_valid outside RESP is ignored and changes no state.
REQ-030 Best-case latency from accept to out_valid is 3 cycles (mem_req_ready=1, response in the next cycle). A misaligned access takes 1 cycle.

Reset
REQ-031 While rst_n=0: state=IDLE, and mem_req_valid, out_valid, out_reg_wen and out_misalign are 0.
REQ-032 While rst_n=0: out_rdata=0, out_rd=0, mem_req_* data fields are 0, and in_ready=1 after release.
REQ-033 Reset asserted mid-transaction abandons it; a late response after release is ignored per REQ-029.

Structure
REQ-034 Package ysyx_22050612_lsu_pkg holds the size encodings, the FSM state enum and the byte-count function.
REQ-035 Sub-module ysyx_22050612_LSU_align: combinational wmask/wdata shift and load extract/extend; the FSM stays in the top module.

Verification
REQ-036 LW at 0x80000004, rdata 0x80000000_12345678 -> out_rdata 0xFFFFFFFF80000000, out_reg_wen=1.
REQ-037 SB at 0x80000003, wdata 0xAB -> mem_req_wmask 0x08, mem_req_wdata 0x00000000AB000000, out_reg_wen=0.
REQ-038 LH at 0x80000007 -> no mem_req_valid pulse, out_valid after 1 cycle with out_misalign=1.
REQ-039 mem_req_ready held low 4 cycles, then out_ready low 3 cycles -> request fields and outputs stay stable throughout, in_ready=0, exactly one bus transaction.
REQ-040 rst_n dropped in RESP, and mem_resp_valid arrives 1 cycle after release -> state IDLE, out_valid stays 0.
REQ-041 LBU at 0x80000006, rdata 0xFF00_0000_0000_0000 upper bytes with byte 6 = 0x9C -> out_rdata 0x000000000000009C.
